dec_share_arbiter: RTL

//  Time-shares one 2-to-4 one-hot decode resource between two requesters.

---
 rtl/dec_share_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dec_share_arbiter.sv
// dec_share_arbiter: two requesters share one 2-to-4 one-hot decoder.
// Round-robin arbitration. Each grant holds the decoded output for HOLD_CYCLES
// cycles, then one dead cycle that pulses done, then a return to IDLE.
//
// Handshake: reqN is a level request. The requester holds it high until ackN.
// ackN is a one-cycle pulse on the edge that latches codeN and starts the hold.
// A request that drops before its ack is never granted, because there is no
// queuing. A request still high after its ack counts as a new request at the
// next IDLE edge.
module dec_share_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req1,
  input  logic [1:0] code1,
  input  logic       req2,
  input  logic [1:0] code2,
  output logic       ack1,
  output logic       ack2,
  output logic [3:0] onehot,
  output logic [1:0] owner,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // 1 = requester 2 owned the most recently completed grant
  logic       last2_q, last2_d;
  logic [3:0] onehot_q, onehot_d;
  logic [1:0] owner_q, owner_d;
  logic       busy_q, busy_d;
  logic       ack1_q, ack1_d;
  logic       ack2_q, ack2_d;
  logic       done_q, done_d;
  logic       win2;

  function automatic logic [3:0] dec2(input logic [1:0] c);
    dec2 = 4'b0001 << c;
  endfunction

  // Requester 2 wins when it is the only requester, or when it ties and requester 1 owned the last grant.
  assign win2 = req2 & (~req1 | ~last2_q);

  // State register and all registered outputs; reset leaves last owner = req2 so req1 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last2_q  <= 1'b1;
      onehot_q <= 4'b0000;
      owner_q  <= 2'b00;
      busy_q   <= 1'b0;
      ack1_q   <= 1'b0;
      ack2_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last2_q  <= last2_d;
      onehot_q <= onehot_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      ack1_q   <= ack1_d;
      ack2_q   <= ack2_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic; ack and done default low so each one is a single-cycle pulse
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last2_d  = last2_q;
    onehot_d = onehot_q;
    owner_d  = owner_q;
    busy_d   = busy_q;
    ack1_d   = 1'b0;
    ack2_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req1 | req2) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          busy_d  = 1'b1;
          if (win2) begin
            owner_d  = 2'b10;
            onehot_d = dec2(code2);
            ack2_d   = 1'b1;
          end else begin
            owner_d  = 2'b01;
            onehot_d = dec2(code1);
            ack1_d   = 1'b1;
          end
        end
      end
      HOLD: begin
        // Outputs stay frozen. Requests and codes are ignored until the count runs out.
        if (cnt_q == '0) begin
          state_d  = GAP;
          onehot_d = 4'b0000;
          owner_d  = 2'b00;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          last2_d  = owner_q[1];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        // Dead cycle. No grant is possible until the following IDLE edge.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign onehot    = onehot_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign ack1      = ack1_q;
  assign ack2      = ack2_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
